// File: rtl/regfile_rename_pkg.sv
// Shared widths and constants for the architectural register file with rename tags.
package regfile_rename_pkg;

    localparam int REG_NUM        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int TAG_WIDTH      = 4;
    localparam int ROB_SIZE       = 1 << TAG_WIDTH;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  busy;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rd_resp_t;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational operand read: stored value/tag, x0 forced to zero, and a bypass
// of a same-cycle commit that resolves the pending tag.
module regfile_read_port
    import regfile_rename_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0]              addr,
    input  logic [REG_NUM-1:0][DATA_WIDTH-1:0]     data_q,
    input  logic [REG_NUM-1:0]                     busy_q,
    input  logic [REG_NUM-1:0][TAG_WIDTH-1:0]      tag_q,
    input  logic                                   if_commit,
    input  logic [REG_ADDR_WIDTH-1:0]              pos_commit,
    input  logic [DATA_WIDTH-1:0]                  data_commit,
    input  logic [TAG_WIDTH-1:0]                   tag_commit,
    output logic                                   busy,
    output logic [DATA_WIDTH-1:0]                  data,
    output logic [TAG_WIDTH-1:0]                   tag
);

    rd_resp_t resp;

    always_comb begin
        resp = '0;
        if (addr != ZERO_REG) begin
            resp.busy = busy_q[addr];
            resp.tag  = tag_q[addr];
            resp.data = data_q[addr];
            // Only the commit that owns the pending tag may resolve it early.
            if (if_commit && pos_commit == addr && busy_q[addr] &&
                tag_q[addr] == tag_commit) begin
                resp.busy = 1'b0;
                resp.data = data_commit;
            end
        end
    end

    assign busy = resp.busy;
    assign data = resp.data;
    assign tag  = resp.tag;

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register ROB rename tags: two bypassed
// read ports, one rename port, one commit port, and flush on misprediction.
module regfile_rename
    import regfile_rename_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic                      rs1_busy,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [TAG_WIDTH-1:0]      rs1_tag,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs2_busy,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic [TAG_WIDTH-1:0]      rs2_tag,
    input  logic                      rename_en,
    input  logic [REG_ADDR_WIDTH-1:0] rename_rd,
    input  logic [TAG_WIDTH-1:0]      rename_tag,
    input  logic                      if_commit,
    input  logic [REG_ADDR_WIDTH-1:0] pos_commit,
    input  logic [DATA_WIDTH-1:0]     data_commit,
    input  logic [TAG_WIDTH-1:0]      tag_commit,
    input  logic                      flush
);

    logic [REG_NUM-1:0][DATA_WIDTH-1:0] data_q;
    logic [REG_NUM-1:0]                 busy_q;
    logic [REG_NUM-1:0][TAG_WIDTH-1:0]  tag_q;

    logic [REG_NUM-1:0] commit_hit;
    logic [REG_NUM-1:0] rename_hit;

    // One-hot decode; bit 0 stays low so x0 is never written.
    always_comb begin
        commit_hit = '0;
        rename_hit = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            commit_hit[i] = if_commit && pos_commit == REG_ADDR_WIDTH'(i);
            rename_hit[i] = rename_en && rename_rd == REG_ADDR_WIDTH'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                // In-order commit: data is always architecturally correct.
                if (commit_hit[i])
                    data_q[i] <= data_commit;
                if (flush) begin
                    busy_q[i] <= 1'b0;
                end else if (rename_hit[i]) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= rename_tag;
                end else if (commit_hit[i] && tag_q[i] == tag_commit) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    regfile_read_port u_rs1 (
        .addr        (rs1_addr),
        .data_q      (data_q),
        .busy_q      (busy_q),
        .tag_q       (tag_q),
        .if_commit   (if_commit),
        .pos_commit  (pos_commit),
        .data_commit (data_commit),
        .tag_commit  (tag_commit),
        .busy        (rs1_busy),
        .data        (rs1_data),
        .tag         (rs1_tag)
    );

    regfile_read_port u_rs2 (
        .addr        (rs2_addr),
        .data_q      (data_q),
        .busy_q      (busy_q),
        .tag_q       (tag_q),
        .if_commit   (if_commit),
        .pos_commit  (pos_commit),
        .data_commit (data_commit),
        .tag_commit  (tag_commit),
        .busy        (rs2_busy),
        .data        (rs2_data),
        .tag         (rs2_tag)
    );

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core.
- Sits directly downstream of the reorder buffer and consumes its commit stream (if_commit, pos_commit, data_commit, tag_commit).
- Serves the decoder: operand reads return either the value or the pending ROB tag, and allocations rename a destination register.
- Flushes all pending tags on a ROB-issued jump (misprediction recovery).

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31).
- REG_ADDR_WIDTH, 5, register index width (`regWidth).
- DATA_WIDTH, 32, register data width (`dataWidth).
- TAG_WIDTH, 4, ROB tag width (`tagWidth); the ROB has 2^TAG_WIDTH entries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state is frozen.
- rs1_addr  in  5  decoder source-1 index.
- rs1_busy  out  1  source-1 value is pending.
- rs1_data  out  32  source-1 value; valid when rs1_busy=0.
- rs1_tag  out  4  ROB tag producing source-1; valid when rs1_busy=1.
- rs2_addr / rs2_busy / rs2_data / rs2_tag  same as rs1, for source 2.
- rename_en  in  1  decoder allocates a destination this cycle.
- rename_rd  in  5  destination register being renamed.
- rename_tag  in  4  ROB tag assigned to that destination.
- if_commit  in  1  ROB commit strobe.
- pos_commit  in  5  committed destination register.
- data_commit  in  32  committed value.
- tag_commit  in  4  ROB tag of the committing entry.
- flush  in  1  misprediction; driven from ROB if_jump.

Behaviour:
- State: data[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (rst=0, asynchronous): all data=0, busy=0, tag=0.
- Reset has no outputs of its own; while in reset, reads return data=0, busy=0, tag=0.
- Reset asserted mid-operation discards all pending renames immediately, without waiting for a clock edge.
- Reads are combinational (zero latency) and reflect pre-edge state, with one commit bypass:
  - If if_commit=1, pos_commit==rsX_addr!=0, busy[rsX]=1 and tag[rsX]==tag_commit, then return busy=0 and data=data_commit.
  - Otherwise return the stored data, busy and tag.
- x0 always reads data=0, busy=0, tag=0; commits and renames targeting x0 are ignored.
- Same-cycle rename does not affect that cycle's reads. The decoder reads its operands before renaming its own rd, so "add x5,x5,x1" sees the old x5.
- Commit at the edge when rdy=1 and if_commit=1:
  - data[pos_commit] <= data_commit, unconditionally (in-order commit keeps the architectural value correct).
  - busy[pos_commit] clears only if tag[pos_commit]==tag_commit and no same-register rename occurs this cycle.
- Rename at the edge when rdy=1 and rename_en=1: busy[rename_rd] <= 1 and tag[rename_rd] <= rename_tag.
- Simultaneous commit and rename of the same register: data is written with data_commit, busy stays 1, and tag takes rename_tag (rename wins).
- Flush at the edge when rdy=1 and flush=1:
  - All busy clear; tags are don't-care.
  - A commit in the same cycle still writes data.
  - A rename in the same cycle is dropped; flush has priority over rename.
- Stale commit (tag mismatch, meaning a younger rename exists): data is written, busy and tag are unchanged.
- rdy=0: no state change, regardless of commit, rename or flush; reads remain live.
- No handshake back-pressure: rename and commit are each accepted every enabled cycle.

Decomposition:
- Shared package (defines.v): `regWidth, `dataWidth, `tagWidth, `robSize, plus a new `zeroReg constant.
- One natural sub-module, regfile_read_port: the combinational read mux with commit bypass and x0 handling. Instantiate it twice (rs1, rs2).

Test Plan:
- Reset then read x7 -> busy=0, data=0; release reset, read x0 after a commit of 0xDEADBEEF to x0 -> data=0, busy=0.
- Rename x5 to tag 3, next cycle read x5 -> busy=1, tag=3; commit x5 tag 3 data 0x12345678, read the same cycle -> bypass gives busy=0, data=0x12345678; next cycle the stored data is 0x12345678.
- Rename x5 to tag 3, then rename x5 to tag 6, commit x5 tag 3 data 0xA -> data=0xA, busy=1, tag=6; commit tag 6 data 0xB -> busy=0, data=0xB.
- Same cycle: commit x9 tag 2 data 0x55 and rename x9 to tag 4 -> next cycle data=0x55, busy=1, tag=4; a same-cycle read of x9 with tag 2 pending bypasses to 0x55.
- Rename x1, x2 and x3 to tags 1, 2, 3; pulse flush together with a rename of x4 to tag 5 -> all busy=0, x4 not busy.
- Hold rdy=0 while driving a rename of x8 to tag 1 and a commit of x8 -> no state change; assert rst low mid-stream -> every busy clears asynchronously before the next edge.
